// File: rtl/adsr_pkg.sv
// Shared encodings and helpers for the per-voice ADSR envelope step engine.
package adsr_pkg;

  localparam int unsigned VOL_W   = 18;
  localparam int unsigned RATE_W  = 7;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned SUM_W   = VOL_W + 1;

  localparam logic [VOL_W-1:0] VOL_MAX = 18'h3FFFF;

  typedef enum logic [STATE_W-1:0] {
    BLANK   = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } adsr_state_e;

  // 7-bit sustain setting placed in the top of the 18-bit volume range.
  function automatic logic [VOL_W-1:0] sus_level(input logic [RATE_W-1:0] sustain);
    return {sustain, 11'b0};
  endfunction

endpackage

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope step: next state/volume and consumed note flags per sample slot.
// Define ADSR_REG_OUT_EN to register all outputs on clk96 (1-cycle latency, sync reset rst).
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter logic [3:0]  DRUM_CHANNEL = 4'd9,
  parameter int unsigned RATE_SHIFT   = 4
) (
  input  logic               clk96,
  input  logic               rst,
  input  logic [RATE_W-1:0]  i_sustain_value,
  input  logic [RATE_W-1:0]  i_attack_rate,
  input  logic [RATE_W-1:0]  i_decay_rate,
  input  logic [RATE_W-1:0]  i_release_rate,
  input  logic [STATE_W-1:0] i_state,
  input  logic [VOL_W-1:0]   i_volume,
  input  logic               i_note_pressed,
  input  logic               i_note_released,
  input  logic [3:0]         i_channel,
  input  logic               i_fifo_empty,
  output logic [STATE_W-1:0] o_state,
  output logic [VOL_W-1:0]   o_volume,
  output logic               o_note_pressed,
  output logic               o_note_released
);

  logic [VOL_W-1:0]   step_a, step_d, step_r, sus_lvl;
  logic [SUM_W-1:0]   atk_sum, dec_floor;
  logic [STATE_W-1:0] nxt_state;
  logic [VOL_W-1:0]   nxt_volume;
  logic               nxt_pressed, nxt_released;

  assign step_a    = VOL_W'(i_attack_rate)  << RATE_SHIFT;
  assign step_d    = VOL_W'(i_decay_rate)   << RATE_SHIFT;
  assign step_r    = VOL_W'(i_release_rate) << RATE_SHIFT;
  assign sus_lvl   = sus_level(i_sustain_value);
  assign atk_sum   = SUM_W'(i_volume) + SUM_W'(step_a);
  assign dec_floor = SUM_W'(sus_lvl) + SUM_W'(step_d);

  // Next state/volume; every arm saturates so volume never wraps.
  always_comb begin
    nxt_state    = i_state;
    nxt_volume   = i_volume;
    nxt_pressed  = i_note_pressed;
    nxt_released = i_note_released;

    if (i_channel != DRUM_CHANNEL) begin
      if (i_note_pressed) begin
        nxt_state   = ATTACK;
        nxt_pressed = 1'b0;
      end else if (i_note_released) begin
        nxt_released = 1'b0;
        if (i_state != BLANK) begin
          nxt_state = RELEASE;
        end else begin
          nxt_state  = BLANK;
          nxt_volume = '0;
        end
      end else begin
        case (i_state)
          ATTACK: begin
            if (atk_sum >= SUM_W'(VOL_MAX)) begin
              nxt_state  = DECAY;
              nxt_volume = VOL_MAX;
            end else begin
              nxt_volume = atk_sum[VOL_W-1:0];
            end
          end
          DECAY: begin
            if (SUM_W'(i_volume) <= dec_floor) begin
              nxt_state  = SUSTAIN;
              nxt_volume = sus_lvl;
            end else begin
              nxt_volume = i_volume - step_d;
            end
          end
          SUSTAIN: ;
          RELEASE: begin
            if (i_volume <= step_r) begin
              nxt_state  = BLANK;
              nxt_volume = '0;
            end else begin
              nxt_volume = i_volume - step_r;
            end
          end
          default: begin
            nxt_state  = BLANK;
            nxt_volume = '0;
          end
        endcase
      end
    end else begin
      // Drum voices ignore the envelope and follow the sample FIFO.
      if (i_note_pressed) begin
        nxt_state   = SUSTAIN;
        nxt_volume  = VOL_MAX;
        nxt_pressed = 1'b0;
      end else if (i_note_released) begin
        nxt_released = 1'b0;
      end else if (i_state > RELEASE || (i_state != BLANK && i_fifo_empty)) begin
        nxt_state  = BLANK;
        nxt_volume = '0;
      end
    end
  end

`ifdef ADSR_REG_OUT_EN
  always_ff @(posedge clk96) begin
    if (rst) begin
      o_state         <= BLANK;
      o_volume        <= '0;
      o_note_pressed  <= 1'b0;
      o_note_released <= 1'b0;
    end else begin
      o_state         <= nxt_state;
      o_volume        <= nxt_volume;
      o_note_pressed  <= nxt_pressed;
      o_note_released <= nxt_released;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst  = &{1'b0, clk96, rst};
  assign o_state         = nxt_state;
  assign o_volume        = nxt_volume;
  assign o_note_pressed  = nxt_pressed;
  assign o_note_released = nxt_released;
`endif

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed vector bench for adsr_envelope; works with or without ADSR_REG_OUT_EN.
module tb_adsr_envelope;
  import adsr_pkg::*;

  logic        clk96 = 1'b0;
  logic        rst;
  logic [6:0]  sus, att, dec, rel;
  logic [2:0]  st;
  logic [17:0] vol;
  logic        np, nr, fe;
  logic [3:0]  ch;
  logic [2:0]  o_state;
  logic [17:0] o_volume;
  logic        o_np, o_nr;

  int checks = 0;
  int errors = 0;

  always #5 clk96 = ~clk96;

  adsr_envelope dut (
    .clk96(clk96), .rst(rst),
    .i_sustain_value(sus), .i_attack_rate(att), .i_decay_rate(dec), .i_release_rate(rel),
    .i_state(st), .i_volume(vol), .i_note_pressed(np), .i_note_released(nr),
    .i_channel(ch), .i_fifo_empty(fe),
    .o_state(o_state), .o_volume(o_volume), .o_note_pressed(o_np), .o_note_released(o_nr)
  );

  typedef struct {
    logic [6:0]  sus, att, dec, rel;
    logic [2:0]  st;
    logic [17:0] vol;
    logic        np, nr;
    logic [3:0]  ch;
    logic        fe;
    logic [2:0]  e_st;
    logic [17:0] e_vol;
    logic        e_np, e_nr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [6:0] s, a, d, r, input logic [2:0] cs,
                              input logic [17:0] cv, input logic p, q, input logic [3:0] c,
                              input logic f, input logic [2:0] es, input logic [17:0] ev,
                              input logic ep, eq);
    vec_t v;
    v.sus = s; v.att = a; v.dec = d; v.rel = r; v.st = cs; v.vol = cv;
    v.np = p; v.nr = q; v.ch = c; v.fe = f;
    v.e_st = es; v.e_vol = ev; v.e_np = ep; v.e_nr = eq;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    sus = v.sus; att = v.att; dec = v.dec; rel = v.rel; st = v.st; vol = v.vol;
    np = v.np; nr = v.nr; ch = v.ch; fe = v.fe;
  endtask

  // One slot: combinational settle, or one clock edge when outputs are registered.
  task automatic settle();
`ifdef ADSR_REG_OUT_EN
    @(posedge clk96);
    #1;
`else
    #1;
`endif
  endtask

  initial begin
    int fin;
    logic released;
    rst = 1'b1;
    sus = '0; att = '0; dec = '0; rel = '0; st = '0; vol = '0;
    np = 1'b0; nr = 1'b0; ch = '0; fe = 1'b0;
    @(negedge clk96);
    settle();
    chk("reset_state", 32'(o_state), 32'(BLANK));
    chk("reset_volume", 32'(o_volume), 32'd0);
    chk("reset_np", 32'(o_np), 32'd0);
    chk("reset_nr", 32'(o_nr), 32'd0);
    rst = 1'b0;

    //          sus  att  dec  rel  state    vol      np nr ch fe  exp_state exp_vol  np nr
    vecs.push_back(mk(0,   0,   0,   0, BLANK,   0,       1, 0, 0, 0, ATTACK,  0,       0, 0));
    vecs.push_back(mk(0,   0,   0,   0, SUSTAIN, 5000,    1, 1, 0, 0, ATTACK,  5000,    0, 1));
    vecs.push_back(mk(0,   32,  0,   0, ATTACK,  'h3FF00, 0, 0, 0, 0, DECAY,   'h3FFFF, 0, 0));
    vecs.push_back(mk(0,   32,  0,   0, ATTACK,  1000,    0, 0, 0, 0, ATTACK,  1512,    0, 0));
    vecs.push_back(mk(0,   32,  0,   0, ATTACK,  'h3FDFF, 0, 0, 0, 0, DECAY,   'h3FFFF, 0, 0));
    vecs.push_back(mk(0,   32,  0,   0, ATTACK,  'h3FDFE, 0, 0, 0, 0, ATTACK,  'h3FFFE, 0, 0));
    vecs.push_back(mk(0,   0,   0,   0, ATTACK,  1000,    0, 0, 0, 0, ATTACK,  1000,    0, 0));
    vecs.push_back(mk(32,  0,   32,  0, DECAY,   65800,   0, 0, 0, 0, SUSTAIN, 65536,   0, 0));
    vecs.push_back(mk(32,  0,   32,  0, DECAY,   70000,   0, 0, 0, 0, DECAY,   69488,   0, 0));
    vecs.push_back(mk(32,  0,   32,  0, DECAY,   66048,   0, 0, 0, 0, SUSTAIN, 65536,   0, 0));
    vecs.push_back(mk(32,  0,   32,  0, DECAY,   66049,   0, 0, 0, 0, DECAY,   65537,   0, 0));
    vecs.push_back(mk(127, 0,   127, 0, DECAY,   262100,  0, 0, 0, 0, SUSTAIN, 260096,  0, 0));
    vecs.push_back(mk(32,  0,   0,   0, SUSTAIN, 65536,   0, 0, 0, 0, SUSTAIN, 65536,   0, 0));
    vecs.push_back(mk(32,  0,   0,   0, SUSTAIN, 65536,   0, 1, 0, 0, RELEASE, 65536,   0, 0));
    vecs.push_back(mk(0,   0,   0,   8, RELEASE, 100,     0, 0, 0, 0, BLANK,   0,       0, 0));
    vecs.push_back(mk(0,   0,   0,   8, RELEASE, 1000,    0, 0, 0, 0, RELEASE, 872,     0, 0));
    vecs.push_back(mk(0,   0,   0,   8, RELEASE, 128,     0, 0, 0, 0, BLANK,   0,       0, 0));
    vecs.push_back(mk(0,   0,   0,   8, RELEASE, 129,     0, 0, 0, 0, RELEASE, 1,       0, 0));
    vecs.push_back(mk(0,   0,   0,   0, BLANK,   0,       0, 1, 0, 0, BLANK,   0,       0, 0));
    vecs.push_back(mk(0,   0,   0,   0, BLANK,   5,       0, 0, 0, 0, BLANK,   0,       0, 0));
    vecs.push_back(mk(0,   0,   0,   0, 3'd6,    777,     0, 0, 0, 0, BLANK,   0,       0, 0));
    vecs.push_back(mk(0,   0,   0,   0, BLANK,   0,       1, 0, 9, 0, SUSTAIN, 'h3FFFF, 0, 0));
    vecs.push_back(mk(0,   0,   0,   0, SUSTAIN, 'h3FFFF, 0, 0, 9, 0, SUSTAIN, 'h3FFFF, 0, 0));
    vecs.push_back(mk(0,   0,   0,   0, SUSTAIN, 'h3FFFF, 0, 0, 9, 1, BLANK,   0,       0, 0));
    vecs.push_back(mk(0,   0,   0,   0, SUSTAIN, 1234,    0, 1, 9, 1, SUSTAIN, 1234,    0, 0));
    vecs.push_back(mk(0,   0,   0,   0, BLANK,   0,       0, 0, 9, 1, BLANK,   0,       0, 0));
    vecs.push_back(mk(0,   0,   0,   0, 3'd7,    50,      0, 0, 9, 0, BLANK,   0,       0, 0));
    vecs.push_back(mk(0,   32,  0,   0, ATTACK,  1000,    0, 0, 9, 0, ATTACK,  1000,    0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      settle();
      chk($sformatf("vec%0d_state", i), 32'(o_state), 32'(vecs[i].e_st));
      chk($sformatf("vec%0d_volume", i), 32'(o_volume), 32'(vecs[i].e_vol));
      chk($sformatf("vec%0d_np", i), 32'(o_np), 32'(vecs[i].e_np));
      chk($sformatf("vec%0d_nr", i), 32'(o_nr), 32'(vecs[i].e_nr));
    end

`ifdef ADSR_REG_OUT_EN
    // Output lags input by one edge, then reset discards the in-flight result.
    drive(mk(0, 32, 0, 0, ATTACK, 1000, 0, 0, 0, 0, ATTACK, 1512, 0, 0));
    #1;
    chk("lag_before_edge", 32'(o_state), 32'(ATTACK));
    chk("lag_before_edge_vol", 32'(o_volume), 32'd1000);
    settle();
    chk("lag_after_edge_vol", 32'(o_volume), 32'd1512);
    drive(mk(0, 32, 0, 0, SUSTAIN, 1000, 1, 1, 0, 0, ATTACK, 1000, 0, 1));
    rst = 1'b1;
    settle();
    chk("midrst_state", 32'(o_state), 32'(BLANK));
    chk("midrst_volume", 32'(o_volume), 32'd0);
    chk("midrst_nr", 32'(o_nr), 32'd0);
    rst = 1'b0;
`endif

    // Full melodic note lifetime fed back slot by slot: exactly one finish.
    sus = 7'd64; att = 7'd127; dec = 7'd127; rel = 7'd127;
    st = BLANK; vol = '0; np = 1'b1; nr = 1'b0; ch = 4'd0; fe = 1'b0;
    fin = 0;
    released = 1'b0;
    for (int slot = 0; slot < 600; slot++) begin
      settle();
      if (o_state == BLANK && st != BLANK) fin++;
      st = o_state; vol = o_volume; np = o_np; nr = o_nr;
      if (o_state == SUSTAIN && !released) begin
        nr = 1'b1;
        released = 1'b1;
      end
    end
    chk("life_finish_count", 32'(fin), 32'd1);
    chk("life_end_state", 32'(st), 32'(BLANK));
    chk("life_end_volume", 32'(vol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Per-voice ADSR envelope step engine for the wavetable synth.
- Once per voice per 48 kHz sample slot, the voice scheduler presents the voice's stored envelope state, volume and note-event flags. The block returns the next state, next volume and updated (consumed) event flags, which the scheduler writes back to voice RAM.
- Drum-channel voices bypass the envelope and track the drum sample FIFO instead.

Parameters:
- DRUM_CHANNEL, 4'd9: MIDI channel handled as a drum voice.
- RATE_SHIFT, 4: left-shift applied to a 7-bit rate to form the per-sample volume step.

Ports:
- clk96 input 1: clock. Used only when ADSR_REG_OUT_EN is defined.
- rst input 1: synchronous, active-high reset. Used only when ADSR_REG_OUT_EN is defined.
- i_sustain_value input 7: sustain level; SUS_LVL = {i_sustain_value, 11'b0}.
- i_attack_rate input 7: attack rate.
- i_decay_rate input 7: decay rate.
- i_release_rate input 7: release rate.
- i_state input 3: current state. BLANK=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- i_volume input 18: current envelope volume.
- i_note_pressed input 1: pending note-on flag.
- i_note_released input 1: pending note-off flag.
- i_channel input 4: voice MIDI channel.
- i_fifo_empty input 1: drum sample FIFO empty.
- o_state output 3: next state.
- o_volume output 18: next volume.
- o_note_pressed output 1: note-on flag after consumption.
- o_note_released output 1: note-off flag after consumption.

Behaviour:
- Default build is purely combinational; outputs are a function of the current inputs only.
- Step sizes are 18-bit: STEP_A = i_attack_rate << RATE_SHIFT, likewise STEP_D and STEP_R. MAX = 18'h3FFFF.
- All add/subtract is done at 19 bits. Results saturate; they never wrap.
- Default flag outputs: o_note_pressed = i_note_pressed, o_note_released = i_note_released, unless a rule below consumes the flag.
- Rules for a melodic voice (i_channel != DRUM_CHANNEL), in priority order:
  1. i_note_pressed=1: o_state=ATTACK, o_volume=i_volume, o_note_pressed=0. o_note_released passes through unchanged, so a simultaneous release is handled in the next slot.
  2. i_note_released=1 with i_state != BLANK: o_state=RELEASE, o_volume=i_volume, o_note_released=0.
  3. i_note_released=1 with i_state == BLANK: o_note_released=0, state stays BLANK, volume 0.
  4. ATTACK: v = i_volume + STEP_A. If v >= MAX, output MAX and DECAY; otherwise output v and stay in ATTACK.
  5. DECAY: if i_volume <= SUS_LVL + STEP_D, output SUS_LVL and SUSTAIN; otherwise output i_volume - STEP_D and stay in DECAY.
  6. SUSTAIN: hold i_volume and SUSTAIN.
  7. RELEASE: if i_volume <= STEP_R, output 0 and BLANK; otherwise output i_volume - STEP_R and stay in RELEASE.
  8. BLANK: output 0 and BLANK.
  9. Codes 5-7: output 0 and BLANK.
- A rate of 0 means no movement in that phase. The state holds until a note event arrives.
- Rules for a drum voice (i_channel == DRUM_CHANNEL), in priority order:
  1. i_note_pressed=1: o_state=SUSTAIN, o_volume=MAX, o_note_pressed=0.
  2. i_note_released=1: o_note_released=0; state and volume are unchanged. The drum plays out its sample.
  3. i_state != BLANK and i_fifo_empty=1: o_state=BLANK, o_volume=0.
  4. Otherwise hold i_state and i_volume. Codes 5-7 go to BLANK with volume 0.
- The scheduler raises its "voice finished" pulse when o_state==BLANK and i_state!=BLANK. The block guarantees this transition happens exactly once per note lifetime.

Optional Feature:
- ADSR_REG_OUT_EN defined: all four outputs are registered on posedge clk96, giving 1-cycle latency.
  - rst=1 forces o_state=BLANK, o_volume=0, o_note_pressed=0, o_note_released=0 on the next edge.
  - Reset mid-operation discards the in-flight result.
- ADSR_REG_OUT_EN undefined: combinational, 0-cycle latency. clk96 and rst are unused.

Decomposition:
- Package adsr_pkg holds:
  - the state encodings BLANK, ATTACK, DECAY, SUSTAIN, RELEASE (3-bit);
  - VOL_MAX = 18'h3FFFF;
  - the sustain-level expansion function.
- No sub-module: a single always_comb next-state/volume block, plus the optional output register.

Test Plan:
- Melodic press: channel 0, i_state=BLANK, i_volume=0, i_note_pressed=1 -> o_state=ATTACK, o_volume=0, o_note_pressed=0.
- Attack saturation: ATTACK, i_volume=18'h3FF00, attack rate 32 (step 512) -> o_state=DECAY, o_volume=18'h3FFFF. With i_volume=1000 -> ATTACK, o_volume=1512.
- Decay to sustain: DECAY, sustain 32 (SUS_LVL=65536), decay rate 32, i_volume=65800 -> SUSTAIN, o_volume=65536. With i_volume=70000 -> DECAY, o_volume=69488.
- Release: SUSTAIN, i_note_released=1 -> RELEASE, o_note_released=0. Then RELEASE, rate 8 (step 128), i_volume=100 -> BLANK, o_volume=0. With i_volume=1000 -> RELEASE, o_volume=872.
- Drum: channel 9, press -> SUSTAIN, volume 18'h3FFFF. Then SUSTAIN with i_fifo_empty=0 -> hold. Then i_fifo_empty=1 -> BLANK, volume 0. Release alone -> flag cleared, state held.
- ADSR_REG_OUT_EN: outputs lag inputs by one clk96 edge. rst=1 -> all outputs 0/BLANK next edge.
